// File: rtl/scan_mux_reg_if.sv
// Channel bus for scan_mux_reg: packed channel data and select controls in,
// registered selected channel and status out.
interface scan_mux_reg_if #(
    parameter int W = 4,
    parameter int N = 4
) ();
    localparam int SELW = $clog2(N);

    logic [N*W-1:0]  din;
    logic            mode;
    logic [SELW-1:0] sel_in;
    logic            hold;
    logic [W-1:0]    y;
    logic [SELW-1:0] ch_out;
    logic            valid;
    logic            wrap;

    modport master (
        output din, mode, sel_in, hold,
        input  y, ch_out, valid, wrap
    );

    modport slave (
        input  din, mode, sel_in, hold,
        output y, ch_out, valid, wrap
    );
endinterface

// File: rtl/scan_mux_reg.sv
// Registered N-channel, W-bit multiplexer with manual select and auto-scan
// (DWELL cycles per channel), hold freeze and end-of-scan wrap pulse.
module scan_mux_reg #(
    parameter int W     = 4,
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic          clk,
    input  logic          rst,
    scan_mux_reg_if.slave bus
);
    localparam int SELW = $clog2(N);
    localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SELW:0]   N_EXT  = (SELW+1)'(N);
    localparam logic [SELW-1:0] P_LAST = SELW'(N - 1);
    localparam logic [CW-1:0]   C_LAST = CW'(DWELL - 1);

    logic [W-1:0]    chan [N];
    logic [W-1:0]    y_q;
    logic [SELW-1:0] ch_q;
    logic            valid_q;
    logic            wrap_q;
    logic [SELW-1:0] p;
    logic [CW-1:0]   cnt;

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chan[k] = bus.din[k*W +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            p       <= '0;
            cnt     <= '0;
        end else if (bus.hold) begin
            wrap_q <= 1'b0;
        end else if (!bus.mode) begin
            // Manual mode parks the scan so re-entry always starts at channel 0
            ch_q   <= bus.sel_in;
            p      <= '0;
            cnt    <= '0;
            wrap_q <= 1'b0;
            if ({1'b0, bus.sel_in} < N_EXT) begin
                y_q     <= chan[bus.sel_in];
                valid_q <= 1'b1;
            end else begin
                y_q     <= '0;
                valid_q <= 1'b0;
            end
        end else begin
            y_q     <= chan[p];
            ch_q    <= p;
            valid_q <= 1'b1;
            if (cnt == C_LAST) begin
                cnt    <= '0;
                p      <= (p == P_LAST) ? '0 : p + SELW'(1);
                wrap_q <= (p == P_LAST);
            end else begin
                cnt    <= cnt + CW'(1);
                wrap_q <= 1'b0;
            end
        end
    end

    assign bus.y      = y_q;
    assign bus.ch_out = ch_q;
    assign bus.valid  = valid_q;
    assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_scan_mux_reg.sv
// Scoreboard bench for scan_mux_reg: a 4-channel and a 3-channel instance,
// directed stimulus pushes expected outputs, a negedge monitor compares.
module tb_scan_mux_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    scan_mux_reg_if #(.W(4), .N(4)) b4 ();
    scan_mux_reg_if #(.W(4), .N(3)) b3 ();

    scan_mux_reg #(.W(4), .N(4), .DWELL(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    scan_mux_reg #(.W(4), .N(3), .DWELL(4)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    typedef struct {
        bit         d3;
        logic [3:0] y;
        logic [1:0] ch;
        logic       v;
        logic       w;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [3:0] chv [4];

    task automatic cyc(input bit d3, input logic r, input logic h, input logic m,
                       input logic [1:0] s, input logic [3:0] ey, input logic [1:0] ech,
                       input logic ev, input logic ew, input string nm);
        exp_t e;
        rst = r;
        if (d3) begin
            b3.hold = h; b3.mode = m; b3.sel_in = s;
        end else begin
            b4.hold = h; b4.mode = m; b4.sel_in = s;
        end
        @(posedge clk);
        #1;
        e.d3 = d3; e.y = ey; e.ch = ech; e.v = ev; e.w = ew; e.name = nm;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0] ay;
        logic [1:0] ach;
        logic av, aw;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.d3) begin
                    ay = b3.y; ach = b3.ch_out; av = b3.valid; aw = b3.wrap;
                end else begin
                    ay = b4.y; ach = b4.ch_out; av = b4.valid; aw = b4.wrap;
                end
                n_cmp++;
                if (ay !== e.y || ach !== e.ch || av !== e.v || aw !== e.w) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got y=%b ch=%0d valid=%b wrap=%b, want y=%b ch=%0d valid=%b wrap=%b",
                             e.name, $time, ay, ach, av, aw, e.y, e.ch, e.v, e.w);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int sels [4];
        int k;
        chv[0] = 4'b0000; chv[1] = 4'b1111; chv[2] = 4'b1001; chv[3] = 4'b0110;
        sels[0] = 0; sels[1] = 2; sels[2] = 1; sels[3] = 3;

        b4.din = 16'b0110_1001_1111_0000;
        b3.din = 12'b1001_1111_0000;
        b4.hold = 0; b4.mode = 0; b4.sel_in = 0;
        b3.hold = 0; b3.mode = 0; b3.sel_in = 0;

        cyc(0, 1, 0, 0, 2'd0, 4'h0, 2'd0, 0, 0, "reset0");
        cyc(0, 1, 0, 1, 2'd3, 4'h0, 2'd0, 0, 0, "reset1");

        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 0, 2'(sels[i]), chv[sels[i]], 2'(sels[i]), 1, 0, "manual");

        cyc(0, 1, 0, 1, 2'd0, 4'h0, 2'd0, 0, 0, "reset_scan");
        for (int i = 0; i < 32; i++) begin
            k = (i / 4) % 4;
            cyc(0, 0, 0, 1, 2'd0, chv[k], 2'(k), 1, (i % 16) == 15, "scan4");
        end

        cyc(0, 1, 0, 1, 2'd0, 4'h0, 2'd0, 0, 0, "reset_hold");
        for (int i = 0; i < 6; i++) begin
            k = i / 4;
            cyc(0, 0, 0, 1, 2'd0, chv[k], 2'(k), 1, 0, "pre_hold");
        end
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 1, 2'd0, chv[1], 2'd1, 1, 0, "hold");
        for (int i = 0; i < 2; i++)
            cyc(0, 0, 0, 1, 2'd0, chv[1], 2'd1, 1, 0, "post_hold_ch1");
        for (int i = 0; i < 2; i++)
            cyc(0, 0, 0, 1, 2'd0, chv[2], 2'd2, 1, 0, "post_hold_ch2");
        cyc(0, 0, 0, 0, 2'd1, chv[1], 2'd1, 1, 0, "mode_switch");
        for (int i = 0; i < 5; i++) begin
            k = i / 4;
            cyc(0, 0, 0, 1, 2'd0, chv[k], 2'(k), 1, 0, "rescan");
        end

        cyc(0, 1, 1, 1, 2'd0, 4'h0, 2'd0, 0, 0, "rst_over_hold");
        for (int i = 0; i < 5; i++) begin
            k = i / 4;
            cyc(0, 0, 0, 1, 2'd0, chv[k], 2'(k), 1, 0, "scan_after_rst");
        end

        // Non-power-of-two channel count: select 3 is out of range
        cyc(1, 1, 0, 0, 2'd0, 4'h0, 2'd0, 0, 0, "n3_reset");
        cyc(1, 0, 0, 0, 2'd3, 4'h0, 2'd3, 0, 0, "n3_oor");
        cyc(1, 0, 0, 0, 2'd2, chv[2], 2'd2, 1, 0, "n3_manual");
        for (int i = 0; i < 14; i++) begin
            k = (i / 4) % 3;
            cyc(1, 0, 0, 1, 2'd0, chv[k], 2'(k), 1, i == 11, "n3_scan");
        end
        cyc(1, 0, 1, 1, 2'd0, chv[0], 2'd0, 1, 0, "n3_hold");

        for (int i = 0; i < 4 && sb_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never compared, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scan_mux_reg.md
Name: scan_mux_reg

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. It is the successor to the lab 4:1 x 4-bit combinational mux.
- Two modes:
  - Manual: channel is chosen by `sel_in`.
  - Auto-scan: channels are stepped 0..N-1 in turn, each held for DWELL cycles.
- Hold control freezes the block. A wrap pulse marks the end of each full scan.
- Used as the channel front-end of the lab display/measurement datapath.

Parameters:
- W, 4, data width per channel (bits), >=1.
- N, 4, number of input channels, >=2.
- SELW, $clog2(N), width of select and channel-index signals (derived; not overridden).
- DWELL, 4, cycles each channel is held in scan mode, >=1.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  N*W  packed channel inputs; channel k at bits [k*W +: W].
- mode  in  1  0 = manual, 1 = auto-scan.
- sel_in  in  SELW  manual-mode channel select.
- hold  in  1  1 = freeze outputs and scan state.
- y  out  W  registered selected channel data.
- ch_out  out  SELW  index of channel currently on y.
- valid  out  1  y holds a legitimately selected channel.
- wrap  out  1  one-cycle pulse when scan pointer returns N-1 -> 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; all outputs are registers.
- Reset:
  - On a rising edge with rst=1: y=0, ch_out=0, valid=0, wrap=0.
  - Internal scan pointer p=0, dwell counter cnt=0.
  - rst has priority over hold, mode and all data.
- Latency: y/ch_out reflect din and select sampled at the previous rising edge (1 cycle). No combinational path from inputs to outputs.
- Priority per edge: rst > hold > mode.
- Hold (rst=0, hold=1):
  - y, ch_out, valid, p and cnt retain their values.
  - wrap=0.
- Manual (rst=0, hold=0, mode=0):
  - If sel_in < N: y <= din channel sel_in, ch_out <= sel_in, valid <= 1.
  - If sel_in >= N (possible when N is not a power of 2): y <= 0, ch_out <= sel_in, valid <= 0.
  - p <= 0, cnt <= 0, wrap <= 0.
- Scan (rst=0, hold=0, mode=1):
  - y <= din channel p, ch_out <= p, valid <= 1.
  - If cnt == DWELL-1:
    - cnt <= 0 and p advances: p <= (p == N-1) ? 0 : p+1.
    - wrap <= 1 only when p == N-1; otherwise wrap <= 0.
  - Else: cnt <= cnt+1, wrap <= 0.
  - Effect: each channel occupies y for exactly DWELL consecutive un-held edges. Wrap asserts on the same edge as the last output of channel N-1.
- Mode switching:
  - Manual clears p and cnt, so every entry into scan starts at channel 0 with a full dwell.
  - Scan -> manual takes effect on the next edge; no partial-dwell state is retained.
- Hold inside a dwell extends that channel's visible time by the held cycles; counting resumes from the frozen cnt.
- DWELL=1: p advances on every un-held scan edge; wrap fires every N cycles.
- din changes while a channel is selected are tracked every un-held edge (y is re-sampled each edge, not latched once per dwell).
- Width rules: cnt is sized $clog2(DWELL) bits (min 1); no arithmetic on data.

Test Plan:
- Reset: W=4, N=4. Assert rst for 2 edges with arbitrary din -> y=0000, ch_out=0, valid=0, wrap=0. Release -> first output appears on the next edge.
- Manual:
  - din = {d=0110, c=1001, b=1111, a=0000}, mode=0.
  - sel_in 00, 10, 01, 11 on successive edges -> y one cycle later = 0000, 1001, 1111, 0110; ch_out matches; valid=1.
- Scan with DWELL=4 (same din), mode=1 from reset:
  - y = 0000 x4, 1111 x4, 1001 x4, 0110 x4, then repeats.
  - wrap=1 only on the 16th output edge.
- Hold:
  - In scan, assert hold for 3 cycles during the 2nd cycle of channel 1 -> y stays 1111, wrap=0.
  - After release, channel 1 is shown for 2 more cycles (4 visible un-held cycles total), then channel 2.
- Mode switch mid-dwell:
  - In scan at channel 2, set mode=0 with sel_in=01 -> next edge y=1111.
  - Return to mode=1 -> scan restarts at channel 0 for a full 4 cycles.
- Out-of-range and rst priority:
  - N=3, manual sel_in=11 -> y=0, valid=0, ch_out=11.
  - rst=1 with hold=1 mid-scan -> all outputs 0, next scan begins at channel 0.
